// File: rtl/pea_instr_controller.sv
// pea_instr_controller: single-issue instruction sequencer for the polynomial
// evaluation accelerator. Accepts one instruction, dispatches a start pulse to
// the STP/EVP/RST unit, waits for its done under a watchdog and returns a
// result/status response over a valid/ready handshake.
module pea_instr_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [31:0]      instr_data,
    output logic             instr_ready,
    output logic             start_stp,
    output logic             start_evp,
    output logic             start_rst,
    output logic [2:0]       cmd_A,
    output logic [4:0]       cmd_N,
    output logic [15:0]      cmd_x,
    input  logic             done_stp,
    input  logic             done_evp,
    input  logic             done_rst,
    input  logic [31:0]      status_stp,
    input  logic [31:0]      result_evp,
    input  logic [31:0]      status_evp,
    output logic             out_valid,
    output logic [31:0]      out_result,
    output logic [31:0]      out_status,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] n_completed
);

    localparam int unsigned     WD_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    localparam logic [31:0] ST_N_TOO_BIG = 32'h2;
    localparam logic [31:0] ST_BAD_OP    = 32'h3;
    localparam logic [31:0] ST_TIMEOUT   = 32'h4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_ISSUE,
        S_WAIT,
        S_RESPOND
    } state_t;

    typedef enum logic [1:0] {
        OP_STP = 2'b00,
        OP_EVP = 2'b01,
        OP_RST = 2'b10,
        OP_INV = 2'b11
    } op_t;

    state_t            r_state;
    state_t            w_state_next;
    op_t               r_op;
    logic [2:0]        r_A;
    logic [4:0]        r_N;
    logic [15:0]       r_x;
    logic [WD_W-1:0]   r_wd;
    logic [31:0]       r_res;
    logic [31:0]       r_stat;
    logic              r_start_stp;
    logic              r_start_evp;
    logic              r_start_rst;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_accept;
    logic              w_capture;
    logic [31:0]       w_res_next;
    logic [31:0]       w_stat_next;
    logic              w_go_stp;
    logic              w_go_evp;
    logic              w_go_rst;
    logic              w_wd_clear;
    logic              w_wd_inc;
    logic              w_consume;
    logic              w_done_sel;
    logic              w_unused_reserved;

    assign w_unused_reserved = ^instr_data[21:16];

    // Select the done strobe of the unit the current instruction targets.
    always_comb begin
        w_done_sel = 1'b0;
        case (r_op)
            OP_STP:  w_done_sel = done_stp;
            OP_EVP:  w_done_sel = done_evp;
            OP_RST:  w_done_sel = done_rst;
            default: w_done_sel = 1'b0;
        endcase
    end

    // Next-state and per-state control decisions.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_res_next   = '0;
        w_stat_next  = '0;
        w_go_stp     = 1'b0;
        w_go_evp     = 1'b0;
        w_go_rst     = 1'b0;
        w_wd_clear   = 1'b0;
        w_wd_inc     = 1'b0;
        w_consume    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (instr_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (r_op == OP_INV) begin
                    w_capture    = 1'b1;
                    w_stat_next  = ST_BAD_OP;
                    w_state_next = S_RESPOND;
                end else if ((r_op == OP_STP) && (r_N == 5'd31)) begin
                    w_capture    = 1'b1;
                    w_stat_next  = ST_N_TOO_BIG;
                    w_state_next = S_RESPOND;
                end else begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_go_stp     = (r_op == OP_STP);
                w_go_evp     = (r_op == OP_EVP);
                w_go_rst     = (r_op == OP_RST);
                w_wd_clear   = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                // A done in the final watchdog cycle takes priority over recovery.
                if (w_done_sel) begin
                    w_capture = 1'b1;
                    case (r_op)
                        OP_STP: w_stat_next = status_stp;
                        OP_EVP: begin
                            w_res_next  = result_evp;
                            w_stat_next = status_evp;
                        end
                        default: w_stat_next = '0;
                    endcase
                    w_state_next = S_RESPOND;
                end else if (r_wd == WD_LAST) begin
                    w_capture    = 1'b1;
                    w_stat_next  = ST_TIMEOUT;
                    w_go_rst     = 1'b1;
                    w_state_next = S_RESPOND;
                end else begin
                    w_wd_inc = 1'b1;
                end
            end
            S_RESPOND: begin
                if (out_ready) begin
                    w_consume    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Command latch, watchdog, response capture, start pulses and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= OP_STP;
            r_A         <= '0;
            r_N         <= '0;
            r_x         <= '0;
            r_wd        <= '0;
            r_res       <= '0;
            r_stat      <= '0;
            r_start_stp <= 1'b0;
            r_start_evp <= 1'b0;
            r_start_rst <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_start_stp <= w_go_stp;
            r_start_evp <= w_go_evp;
            r_start_rst <= w_go_rst;
            if (w_accept) begin
                r_op <= op_t'(instr_data[31:30]);
                r_A  <= instr_data[29:27];
                r_N  <= instr_data[26:22];
                r_x  <= instr_data[15:0];
            end
            if (w_wd_clear) begin
                r_wd <= '0;
            end else if (w_wd_inc) begin
                r_wd <= r_wd + 1'b1;
            end
            if (w_capture) begin
                r_res  <= w_res_next;
                r_stat <= w_stat_next;
            end
            if (w_consume) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Every output is forced low while rst is asserted, including registered ones.
    assign instr_ready = (r_state == S_IDLE) && !rst;
    assign busy        = (r_state != S_IDLE) && !rst;
    assign out_valid   = (r_state == S_RESPOND) && !rst;
    assign start_stp   = r_start_stp && !rst;
    assign start_evp   = r_start_evp && !rst;
    assign start_rst   = r_start_rst && !rst;
    assign cmd_A       = rst ? '0 : r_A;
    assign cmd_N       = rst ? '0 : r_N;
    assign cmd_x       = rst ? '0 : r_x;
    assign out_result  = rst ? '0 : r_res;
    assign out_status  = rst ? '0 : r_stat;
    assign n_completed = rst ? '0 : r_cnt;

endmodule

// File: tb/tb_pea_instr_controller.sv
// Bench for pea_instr_controller: transaction-level timing model plus
// literal spot checks of headline behaviours.
module tb_pea_instr_controller;

    localparam int TO    = 8;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             instr_valid;
    logic [31:0]      instr_data;
    logic             instr_ready;
    logic             start_stp, start_evp, start_rst;
    logic [2:0]       cmd_A;
    logic [4:0]       cmd_N;
    logic [15:0]      cmd_x;
    logic             done_stp, done_evp, done_rst;
    logic [31:0]      status_stp, result_evp, status_evp;
    logic             out_valid;
    logic [31:0]      out_result, out_status;
    logic             out_ready;
    logic             busy;
    logic [CNT_W-1:0] n_completed;

    pea_instr_controller #(.TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_data(instr_data), .instr_ready(instr_ready),
        .start_stp(start_stp), .start_evp(start_evp), .start_rst(start_rst),
        .cmd_A(cmd_A), .cmd_N(cmd_N), .cmd_x(cmd_x),
        .done_stp(done_stp), .done_evp(done_evp), .done_rst(done_rst),
        .status_stp(status_stp), .result_evp(result_evp), .status_evp(status_evp),
        .out_valid(out_valid), .out_result(out_result), .out_status(out_status),
        .out_ready(out_ready), .busy(busy), .n_completed(n_completed)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    // Expected behaviour per cycle index, filled in by the drivers.
    bit [2:0]    e_start [int];   // {rst, evp, stp}
    bit          e_busy  [int];
    bit          e_valid [int];
    logic [31:0] e_res   [int];
    logic [31:0] e_stat  [int];
    bit          e_inc   [int];
    bit          e_clr   [int];
    logic [23:0] e_cmd   [int];

    logic [CNT_W-1:0] m_cnt = '0;
    logic [23:0]      m_cmd = '0;

    // Observations used by the literal checks.
    int          n_sstp = 0, n_sevp = 0, n_srst = 0;
    int          last_sstp_cyc = 0, last_sevp_cyc = 0, last_srst_cyc = 0;
    logic [31:0] last_res = '0, last_stat = '0;
    int          n_unstable = 0;
    bit          p_hold = 0;
    logic [31:0] p_res = '0, p_stat = '0;
    bit [2:0]    xs;
    bit          xb, xv;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (e_clr.exists(cyc)) begin
            m_cnt = '0;
            m_cmd = '0;
        end
        if (e_inc.exists(cyc)) m_cnt = m_cnt + 1'b1;
        if (e_cmd.exists(cyc)) m_cmd = e_cmd[cyc];
        if (rst) begin
            check("rst_ctl", {instr_ready, start_stp, start_evp, start_rst, out_valid, busy}, 0);
            check("rst_cmd", {cmd_A, cmd_N, cmd_x}, 0);
            check("rst_out", {out_result, out_status}, 0);
            check("rst_cnt", n_completed, 0);
            p_hold = 0;
        end else begin
            xs = e_start.exists(cyc) ? e_start[cyc] : 3'b000;
            xb = e_busy.exists(cyc);
            xv = e_valid.exists(cyc);
            check("start", {start_rst, start_evp, start_stp}, xs);
            check("busy", busy, xb);
            check("instr_ready", instr_ready, !xb);
            check("out_valid", out_valid, xv);
            if (xv) begin
                check("out_result", out_result, e_res[cyc]);
                check("out_status", out_status, e_stat[cyc]);
            end
            check("n_completed", n_completed, m_cnt);
            check("cmd", {cmd_A, cmd_N, cmd_x}, m_cmd);
            if (start_stp) begin n_sstp++; last_sstp_cyc = cyc; end
            if (start_evp) begin n_sevp++; last_sevp_cyc = cyc; end
            if (start_rst) begin n_srst++; last_srst_cyc = cyc; end
            if (out_valid && out_ready) begin
                last_res  = out_result;
                last_stat = out_status;
            end
            if (p_hold && out_valid && ((out_result !== p_res) || (out_status !== p_stat)))
                n_unstable++;
            p_hold = out_valid && !out_ready;
            p_res  = out_result;
            p_stat = out_status;
        end
    end

    task automatic drive_idle();
        instr_valid = 1'b0;
        instr_data  = $urandom;
        done_stp    = 1'b0;
        done_evp    = 1'b0;
        done_rst    = 1'b0;
        status_stp  = $urandom;
        result_evp  = $urandom;
        status_evp  = $urandom;
        out_ready   = 1'($urandom_range(0, 1));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            drive_idle();
            rst = 1'b1;
            e_clr[cyc] = 1'b1;
            tick();
        end
        rst = 1'b0;
        drive_idle();
    endtask

    function automatic bit [2:0] unit_of(input logic [1:0] op);
        return (op == 2'b00) ? 3'b001 : (op == 2'b01) ? 3'b010 : 3'b100;
    endfunction

    // One instruction: dly = cycles from start pulse to done (-1: never),
    // bp = cycles of out_ready low once the response is up,
    // stray: 0 none, 1 wrong-unit done one cycle after start, 2 random cycle.
    task automatic run_instr(input logic [31:0] instr, input int dly, input int bp, input int gap,
                             input bit hold, input int stray, input logic [31:0] vr,
                             input logic [31:0] vs, output int t_acc);
        int t, s, r, h, dc, sc;
        logic [1:0] op;
        bit [2:0] sel, ssel;
        logic [31:0] xr, xst;
        repeat (gap) begin
            drive_idle();
            tick();
        end
        t   = cyc;
        op  = instr[31:30];
        sel = unit_of(op);
        ssel = {sel[1:0], sel[2]};
        s   = t + 3;
        dc  = -1;
        e_cmd[t+1] = {instr[29:27], instr[26:22], instr[15:0]};
        if (op == 2'b11) begin
            r = t + 2; xr = 0; xst = 32'h3;
        end else if (op == 2'b00 && instr[26:22] == 5'd31) begin
            r = t + 2; xr = 0; xst = 32'h2;
        end else begin
            e_start[s] = sel;
            if (dly >= 0) dc = s + dly;
            if (dly >= 0 && dly + 1 <= TO) begin
                r   = dc + 1;
                xr  = (op == 2'b01) ? vr : 32'h0;
                xst = (op == 2'b10) ? 32'h0 : vs;
            end else begin
                r = s + TO;
                e_start[r] = 3'b100;
                xr = 0; xst = 32'h4;
            end
        end
        h = r + bp;
        for (int c = t + 1; c <= h; c++) e_busy[c] = 1'b1;
        for (int c = r; c <= h; c++) begin
            e_valid[c] = 1'b1;
            e_res[c]   = xr;
            e_stat[c]  = xst;
        end
        e_inc[h+1] = 1'b1;
        sc = (stray == 1) ? s + 1 : (stray == 2) ? $urandom_range(t + 1, h) : -1;

        drive_idle();
        instr_valid = 1'b1;
        instr_data  = instr;
        tick();
        for (int c = t + 1; c <= h; c++) begin
            drive_idle();
            instr_valid = hold;
            {done_rst, done_evp, done_stp} = ((c == dc) ? sel : 3'b000) | ((c == sc) ? ssel : 3'b000);
            if (c == dc) begin
                status_stp = vs;
                result_evp = vr;
                status_evp = vs;
            end
            out_ready = (c >= h) ? 1'b1 : (c < r) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        drive_idle();
        t_acc = t;
    endtask

    // Issue an instruction and assert reset k cycles into WAIT.
    task automatic run_rst_mid(input logic [31:0] instr, input int k);
        int t, s, rc;
        bit [2:0] sel;
        t   = cyc;
        sel = unit_of(instr[31:30]);
        s   = t + 3;
        rc  = s + k;
        e_cmd[t+1] = {instr[29:27], instr[26:22], instr[15:0]};
        e_start[s] = sel;
        for (int c = t + 1; c < rc; c++) e_busy[c] = 1'b1;
        e_clr[rc] = 1'b1;
        drive_idle();
        instr_valid = 1'b1;
        instr_data  = instr;
        tick();
        for (int c = t + 1; c < rc; c++) begin
            drive_idle();
            tick();
        end
        drive_idle();
        rst = 1'b1;
        {done_rst, done_evp, done_stp} = sel;
        tick();
        rst = 1'b0;
        drive_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    int t1, t2, b_stp, b_evp, b_rst;
    int wrap_exp[5] = '{1, 2, 3, 0, 1};
    logic [31:0] rins;
    int rdly;

    initial begin
        rst = 1'b1;
        drive_idle();
        do_reset(3);
        @(negedge clk);
        check("lit_idle_ready", instr_ready, 1);
        check("lit_idle_busy", busy, 0);
        tick();

        // EVP A=2 N=10 x=3, done 5 cycles after start
        b_evp = n_sevp;
        run_instr(32'h5280_0003, 5, 0, 0, 0, 0, 32'h0000_01F4, 32'h0, t1);
        @(negedge clk);
        check("lit_evp_pulses", n_sevp - b_evp, 1);
        check("lit_evp_latency", last_sevp_cyc - t1, 3);
        check("lit_evp_result", last_res, 32'h1F4);
        check("lit_evp_status", last_stat, 0);
        check("lit_cmd_A", cmd_A, 2);
        check("lit_cmd_N", cmd_N, 10);
        check("lit_cmd_x", cmd_x, 3);
        check("lit_count1", n_completed, 1);
        tick();

        // Rejected at decode: invalid opcode, then STP with N=31
        b_stp = n_sstp; b_evp = n_sevp; b_rst = n_srst;
        run_instr(32'hC000_0000, 2, 1, 1, 0, 0, $urandom, $urandom, t1);
        @(negedge clk);
        check("lit_badop_status", last_stat, 3);
        check("lit_badop_result", last_res, 0);
        tick();
        run_instr(32'h07C0_0000, 2, 0, 0, 0, 0, $urandom, $urandom, t1);
        @(negedge clk);
        check("lit_ntoobig_status", last_stat, 2);
        check("lit_rejected_pulses", (n_sstp - b_stp) + (n_sevp - b_evp) + (n_srst - b_rst), 0);
        tick();

        // Watchdog: STP never done
        b_stp = n_sstp; b_rst = n_srst;
        run_instr(32'h0880_0005, -1, 0, 0, 0, 0, $urandom, $urandom, t1);
        @(negedge clk);
        check("lit_wd_rst_pulses", n_srst - b_rst, 1);
        check("lit_wd_stp_pulses", n_sstp - b_stp, 1);
        check("lit_wd_delay", last_srst_cyc - last_sstp_cyc, TO);
        check("lit_wd_status", last_stat, 4);
        tick();

        // Done in the final watchdog cycle wins
        b_rst = n_srst;
        run_instr(32'h0880_0005, TO - 1, 0, 0, 0, 0, $urandom, 32'hABCD_0001, t1);
        @(negedge clk);
        check("lit_wd_race_pulses", n_srst - b_rst, 0);
        check("lit_wd_race_status", last_stat, 32'hABCD_0001);
        tick();

        // Done one cycle too late is ignored
        run_instr(32'h0880_0005, TO, 0, 0, 0, 0, $urandom, 32'h1234_5678, t1);
        @(negedge clk);
        check("lit_wd_late_status", last_stat, 4);
        tick();

        // Backpressure with instr_valid held, next instruction right behind
        run_instr(32'h4000_0007, 2, 10, 0, 1, 0, 32'hCAFE_F00D, 32'h0000_0055, t1);
        run_instr(32'h8000_0000, 1, 0, 0, 0, 0, $urandom, $urandom, t2);
        @(negedge clk);
        check("lit_bp_stable", n_unstable, 0);
        tick();

        // Stray EVP done during an STP wait
        run_instr(32'h1100_0000, 3, 0, 0, 0, 1, $urandom, 32'h5A5A_0007, t1);
        @(negedge clk);
        check("lit_stray_status", last_stat, 32'h5A5A_0007);
        check("lit_stray_result", last_res, 0);
        tick();

        // Reset mid-WAIT discards everything
        run_rst_mid(32'h4000_0001, 3);
        @(negedge clk);
        check("lit_rst_count", n_completed, 0);
        check("lit_rst_valid", out_valid, 0);
        check("lit_rst_ready", instr_ready, 1);
        tick();

        // Counter wrap
        do_reset(2);
        for (int i = 0; i < 5; i++) begin
            run_instr(32'h8000_0000, 1, 0, 0, 0, 0, $urandom, $urandom, t1);
            @(negedge clk);
            check("lit_wrap", n_completed, wrap_exp[i]);
            tick();
        end

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            rins = $urandom;
            if ($urandom_range(0, 7) == 0) rins[31:22] = {2'b00, 3'($urandom_range(0, 7)), 5'd31};
            rdly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TO + 1));
            run_instr(rins, rdly, $urandom_range(0, 3), $urandom_range(0, 2),
                      1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom, $urandom, t1);
        end

        drive_idle();
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
